// File: rtl/fetch_req.sv
// fetch_req: instruction-fetch request stage; owns the PC, drives the ibus handshake, applies redirects.
// Define FETCH_PERF_EN to add the perf_wait_cycles bus-wait counter output.
module fetch_req #(
    parameter logic [63:0] PC_RESET  = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        ireq_data_ok,
    input  logic [31:0] ireq_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0] perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        REQ       = 2'd0,
        WAIT_DATA = 2'd1,
        OUT       = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        ireq_valid_q, ireq_valid_d;
    logic [63:0] ireq_addr_q, ireq_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;

    logic accepted;
    logic aligned;

    assign accepted = ireq_valid_q & ireq_addr_ok;
    assign aligned  = (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ: begin
                // An accepted request must still have its response drained, even when redirected.
                if (redirect_valid) begin
                    state_d = (accepted && !ireq_data_ok) ? WAIT_DATA : REQ;
                end else if (!aligned) begin
                    state_d = OUT;
                end else if (accepted) begin
                    state_d = ireq_data_ok ? OUT : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (ireq_data_ok) begin
                    state_d = (redirect_valid || discard_q) ? REQ : OUT;
                end
            end
            OUT: begin
                if (redirect_valid || !stall) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        discard_d    = discard_q;
        ireq_valid_d = ireq_valid_q;
        ireq_addr_d  = ireq_addr_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        out_valid_d  = (state_d == OUT);
        case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    ireq_valid_d = 1'b0;
                    discard_d    = accepted && !ireq_data_ok;
                end else if (!aligned) begin
                    out_pc_d    = pc_q;
                    out_instr_d = NOP_INSTR;
                end else if (!ireq_valid_q) begin
                    ireq_valid_d = 1'b1;
                    ireq_addr_d  = pc_q;
                end else if (ireq_addr_ok) begin
                    ireq_valid_d = 1'b0;
                    if (ireq_data_ok) begin
                        out_pc_d    = pc_q;
                        out_instr_d = ireq_data;
                    end
                end
            end
            WAIT_DATA: begin
                if (ireq_data_ok) begin
                    discard_d = 1'b0;
                    if (!redirect_valid && !discard_q) begin
                        out_pc_d    = pc_q;
                        out_instr_d = ireq_data;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            OUT: begin
                if (!redirect_valid && !stall) begin
                    pc_d = pc_q + 64'd4;
                end
            end
            default: ;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q         <= PC_RESET;
            discard_q    <= 1'b0;
            ireq_valid_q <= 1'b0;
            ireq_addr_q  <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            ireq_valid_q <= ireq_valid_d;
            ireq_addr_q  <= ireq_addr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    assign ireq_valid = ireq_valid_q;
    assign ireq_addr  = ireq_addr_q;
    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_instr  = out_instr_q;

`ifdef FETCH_PERF_EN
    logic [63:0] perf_q, perf_d;
    logic        perf_inc;

    assign perf_inc = ((state_q == REQ) && ireq_valid_q && !ireq_addr_ok) || (state_q == WAIT_DATA);

    always_comb begin
        perf_d = perf_q;
        if (perf_inc && (perf_q != '1)) begin
            perf_d = perf_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_wait_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fetch_req.sv
// tb_fetch_req: directed stimulus for fetch_req with a transaction-level reference model.
// Build with FETCH_PERF_EN defined to also check perf_wait_cycles.
module tb_fetch_req;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        ireq_addr_ok = 1'b0;
    logic        ireq_data_ok = 1'b0;
    logic [31:0] ireq_data = '0;

    logic        ireq_valid, ireq_valid2;
    logic [63:0] ireq_addr, ireq_addr2;
    logic        out_valid, out_valid2;
    logic [63:0] out_pc, out_pc2;
    logic [31:0] out_instr, out_instr2;
`ifdef FETCH_PERF_EN
    logic [63:0] perf, perf2;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    fetch_req dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .ireq_addr_ok(ireq_addr_ok), .ireq_data_ok(ireq_data_ok), .ireq_data(ireq_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr)
`ifdef FETCH_PERF_EN
        , .perf_wait_cycles(perf)
`endif
    );

    // Second instance sees identical stimulus; only its reset PC differs (wrap check).
    fetch_req #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk(clk), .resetn(resetn), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ireq_valid(ireq_valid2), .ireq_addr(ireq_addr2),
        .ireq_addr_ok(ireq_addr_ok), .ireq_data_ok(ireq_data_ok), .ireq_data(ireq_data),
        .out_valid(out_valid2), .out_pc(out_pc2), .out_instr(out_instr2)
`ifdef FETCH_PERF_EN
        , .perf_wait_cycles(perf2)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. Phases: 0 = about to issue, 1 = request on bus,
    // 2 = awaiting data, 3 = presenting an instruction.
    int unsigned m_phase;
    logic        m_killed;
    logic [63:0] m_pc;
    logic        m_req_valid;
    logic [63:0] m_req_addr;
    logic        m_out_valid;
    logic [63:0] m_out_pc;
    logic [31:0] m_out_instr;
    logic [63:0] m_perf;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase     <= 0;
            m_killed    <= 1'b0;
            m_pc        <= 64'h0000_0000_8000_0000;
            m_req_valid <= 1'b0;
            m_req_addr  <= '0;
            m_out_valid <= 1'b0;
            m_out_pc    <= '0;
            m_out_instr <= '0;
            m_perf      <= '0;
        end else begin
            if (((m_phase == 1) && !ireq_addr_ok) || (m_phase == 2)) begin
                if (m_perf != '1) m_perf <= m_perf + 64'd1;
            end
            if (redirect_valid) begin
                m_pc        <= redirect_pc;
                m_req_valid <= 1'b0;
                m_out_valid <= 1'b0;
                if ((m_phase == 1) && ireq_addr_ok && !ireq_data_ok) begin
                    m_phase  <= 2;
                    m_killed <= 1'b1;
                end else if ((m_phase == 2) && !ireq_data_ok) begin
                    m_killed <= 1'b1;
                end else begin
                    m_phase  <= 0;
                    m_killed <= 1'b0;
                end
            end else begin
                case (m_phase)
                    0: begin
                        if (m_pc[1:0] != 2'b00) begin
                            m_out_valid <= 1'b1;
                            m_out_pc    <= m_pc;
                            m_out_instr <= 32'h0000_0013;
                            m_phase     <= 3;
                        end else begin
                            m_req_valid <= 1'b1;
                            m_req_addr  <= m_pc;
                            m_phase     <= 1;
                        end
                    end
                    1: begin
                        if (ireq_addr_ok) begin
                            m_req_valid <= 1'b0;
                            if (ireq_data_ok) begin
                                m_out_valid <= 1'b1;
                                m_out_pc    <= m_pc;
                                m_out_instr <= ireq_data;
                                m_phase     <= 3;
                            end else begin
                                m_phase <= 2;
                            end
                        end
                    end
                    2: begin
                        if (ireq_data_ok) begin
                            if (m_killed) begin
                                m_killed <= 1'b0;
                                m_phase  <= 0;
                            end else begin
                                m_out_valid <= 1'b1;
                                m_out_pc    <= m_pc;
                                m_out_instr <= ireq_data;
                                m_phase     <= 3;
                            end
                        end
                    end
                    default: begin
                        if (!stall) begin
                            m_pc        <= m_pc + 64'd4;
                            m_out_valid <= 1'b0;
                            m_phase     <= 0;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("m_ireq_valid", ireq_valid, m_req_valid);
        chk("m_ireq_addr", ireq_addr, m_req_addr);
        chk("m_out_valid", out_valid, m_out_valid);
        chk("m_out_pc", out_pc, m_out_pc);
        chk("m_out_instr", out_instr, m_out_instr);
`ifdef FETCH_PERF_EN
        chk("m_perf", perf, m_perf);
`endif
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(input int unsigned budget);
        int unsigned n = 0;
        while ((ireq_valid !== 1'b1) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (ireq_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: ireq_valid %b after %0d cycles, expected 1", ireq_valid, budget);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ireq_valid"}, ireq_valid, 64'd0);
        chk({tag, "_ireq_addr"}, ireq_addr, 64'd0);
        chk({tag, "_out_valid"}, out_valid, 64'd0);
        chk({tag, "_out_pc"}, out_pc, 64'd0);
        chk({tag, "_out_instr"}, out_instr, 64'd0);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf"}, perf, 64'd0);
        chk({tag, "_perf2"}, perf2, 64'd0);
`endif
    endtask

    initial begin
        repeat (2) tick();
        chk_reset_values("rst");
        resetn = 1'b1;

        // 1: basic fetch, addr_ok then data_ok one cycle later
        wait_req(4);
        chk("t1_addr", ireq_addr, 64'h0000_0000_8000_0000);
        chk("t5_first_addr", ireq_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        ireq_addr_ok = 1'b1;
        tick();
        ireq_addr_ok = 1'b0;
        ireq_data_ok = 1'b1;
        ireq_data    = 32'h0000_0093;
        tick();
        ireq_data_ok = 1'b0;
        chk("t1_out_valid", out_valid, 64'd1);
        chk("t1_out_pc", out_pc, 64'h0000_0000_8000_0000);
        chk("t1_out_instr", out_instr, 64'h0000_0093);
        chk("t1_model_out_pc", m_out_pc, 64'h0000_0000_8000_0000);
        chk("t5_out_valid", out_valid2, 64'd1);
        chk("t5_out_pc", out_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_out_instr", out_instr2, 64'h0000_0093);
        wait_req(4);
        chk("t1_next_addr", ireq_addr, 64'h0000_0000_8000_0004);
        chk("t1_model_next_addr", m_req_addr, 64'h0000_0000_8000_0004);
        chk("t5_wrap_valid", ireq_valid2, 64'd1);
        chk("t5_wrap_addr", ireq_addr2, 64'd0);

        // 2: addr_ok+data_ok together, then stall for 3 cycles in OUT
        ireq_addr_ok = 1'b1;
        ireq_data_ok = 1'b1;
        ireq_data    = 32'h0010_0113;
        stall        = 1'b1;
        tick();
        ireq_addr_ok = 1'b0;
        ireq_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_valid", out_valid, 64'd1);
            chk("t2_hold_pc", out_pc, 64'h0000_0000_8000_0004);
            chk("t2_hold_instr", out_instr, 64'h0010_0113);
            chk("t2_no_req", ireq_valid, 64'd0);
        end
        stall = 1'b0;
        wait_req(4);
        chk("t2_next_addr", ireq_addr, 64'h0000_0000_8000_0008);

        // 3: redirect while waiting for data; the late data must be dropped
        ireq_addr_ok = 1'b1;
        tick();
        ireq_addr_ok   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1000;
        tick();
        redirect_valid = 1'b0;
        ireq_data_ok   = 1'b1;
        ireq_data      = 32'hDEAD_BEEF;
        tick();
        ireq_data_ok = 1'b0;
        chk("t3_no_out", out_valid, 64'd0);
        wait_req(4);
        chk("t3_addr", ireq_addr, 64'h0000_0000_8000_1000);
        chk("t3_instr_kept", out_instr, 64'h0010_0113);

        // 4: redirect withdraws a pending request, misaligned target yields NOP
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0002;
        tick();
        redirect_valid = 1'b0;
        chk("t4_withdrawn", ireq_valid, 64'd0);
        tick();
        chk("t4_out_valid", out_valid, 64'd1);
        chk("t4_out_pc", out_pc, 64'h0000_0000_8000_0002);
        chk("t4_out_instr", out_instr, 64'h0000_0013);
        chk("t4_no_req", ireq_valid, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_2000;
        tick();
        redirect_valid = 1'b0;
        chk("t4_redir_out", out_valid, 64'd0);
        wait_req(4);
        chk("t4_addr", ireq_addr, 64'h0000_0000_8000_2000);

        // redirect coinciding with addr_ok: the response is drained and dropped
        ireq_addr_ok   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_3000;
        tick();
        ireq_addr_ok   = 1'b0;
        redirect_valid = 1'b0;
        chk("tx_acc_valid", ireq_valid, 64'd0);
        tick();
        ireq_data_ok = 1'b1;
        ireq_data    = 32'hBADB_AD00;
        tick();
        ireq_data_ok = 1'b0;
        chk("tx_acc_drop", out_valid, 64'd0);
        wait_req(4);
        chk("tx_acc_addr", ireq_addr, 64'h0000_0000_8000_3000);

        // redirect with addr_ok and data_ok together
        ireq_addr_ok   = 1'b1;
        ireq_data_ok   = 1'b1;
        ireq_data      = 32'h0000_0517;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_4000;
        tick();
        ireq_addr_ok   = 1'b0;
        ireq_data_ok   = 1'b0;
        redirect_valid = 1'b0;
        chk("tx_both_drop", out_valid, 64'd0);
        wait_req(4);
        chk("tx_both_addr", ireq_addr, 64'h0000_0000_8000_4000);

        // redirect overrides stall in OUT
        ireq_addr_ok = 1'b1;
        ireq_data_ok = 1'b1;
        ireq_data    = 32'h0000_0617;
        stall        = 1'b1;
        tick();
        ireq_addr_ok = 1'b0;
        ireq_data_ok = 1'b0;
        chk("tx_stall_valid", out_valid, 64'd1);
        chk("tx_stall_pc", out_pc, 64'h0000_0000_8000_4000);
        chk("tx_stall_instr", out_instr, 64'h0000_0617);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_5000;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("tx_stall_redir", out_valid, 64'd0);
        wait_req(4);
        chk("tx_stall_addr", ireq_addr, 64'h0000_0000_8000_5000);

        // 6: asynchronous reset while waiting for data
        ireq_addr_ok = 1'b1;
        tick();
        ireq_addr_ok = 1'b0;
        repeat (2) tick();
        #2 resetn = 1'b0;
        #1 chk_reset_values("t6");
        tick();
        resetn = 1'b1;
        wait_req(4);
        chk("t6_restart_addr", ireq_addr, 64'h0000_0000_8000_0000);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
